ibus_dbus_arb: RTL and testbench

- Shares one single-ported memory bus between instruction fetch (PC/fetch stage) and the load/store (MEM) stage.
- Issues bus requests and holds each one until acknowledged.
- Returns read data to the winning requester.
- Raises stall requests to the pipeline controller, which folds them into the 6-bit stall vector.

---
 rtl/arb_pkg.sv | 17 +
 rtl/arb_wait_cnt.sv | 38 +++
 rtl/ibus_dbus_arb.sv | 201 ++++++++++++++++++++
 tb/tb_ibus_dbus_arb.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the instruction/data bus arbiter
package arb_pkg;

   // Shared core widths: instruction address and data word
   localparam int N_INST_ADDR = 32;
   localparam int N_INST_DATA = 32;

   // Byte select used for every instruction fetch (full word)
   localparam logic [3:0] SEL_WORD = 4'hF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IF_BUSY  = 2'd1,
      MEM_BUSY = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_wait_cnt.sv
// rtl/arb_wait_cnt.sv - bus acknowledge wait counter used for the ARB_TIMEOUT_EN timeout
module arb_wait_cnt #(
   parameter int MAX_WAIT = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_hit
);

   localparam int W = $clog2(MAX_WAIT + 1);

   logic [W-1:0] cnt_q, cnt_d;

   // Restart at grant; count busy cycles without ack, saturating at MAX_WAIT
   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en && (cnt_q != W'(MAX_WAIT))) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Counter register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Hit in the MAX_WAIT-th busy cycle so the request is held exactly MAX_WAIT cycles
   assign o_hit = (cnt_q == W'(MAX_WAIT - 1));

endmodule

// File: rtl/ibus_dbus_arb.sv
// rtl/ibus_dbus_arb.sv - fetch/load-store arbiter for one shared memory bus (optional timeout: ARB_TIMEOUT_EN)
module ibus_dbus_arb
   import arb_pkg::*;
#(
   parameter int N_ADDR   = N_INST_ADDR,
   parameter int N_DATA   = N_INST_DATA,
   parameter int MAX_WAIT = 15
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_if_ce,
   input  logic [N_ADDR-1:0] i_if_addr,
   output logic [N_DATA-1:0] o_if_rdata,
   output logic              o_if_vld,
   input  logic              i_mem_req,
   input  logic              i_mem_we,
   input  logic [3:0]        i_mem_sel,
   input  logic [N_ADDR-1:0] i_mem_addr,
   input  logic [N_DATA-1:0] i_mem_wdata,
   output logic [N_DATA-1:0] o_mem_rdata,
   output logic              o_mem_vld,
   output logic              o_bus_req,
   output logic              o_bus_we,
   output logic [3:0]        o_bus_sel,
   output logic [N_ADDR-1:0] o_bus_addr,
   output logic [N_DATA-1:0] o_bus_wdata,
   input  logic              i_bus_ack,
   input  logic [N_DATA-1:0] i_bus_rdata,
`ifdef ARB_TIMEOUT_EN
   output logic              o_bus_err,
`endif
   output logic              o_stallreq_if,
   output logic              o_stallreq_mem
);

   arb_state_t        state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [3:0]        bus_sel_q, bus_sel_d;
   logic [N_ADDR-1:0] bus_addr_q, bus_addr_d;
   logic [N_DATA-1:0] bus_wdata_q, bus_wdata_d;
   logic [N_DATA-1:0] if_rdata_q, if_rdata_d;
   logic [N_DATA-1:0] mem_rdata_q, mem_rdata_d;
   logic              if_vld_q, if_vld_d;
   logic              mem_vld_q, mem_vld_d;
   logic              fair_q, fair_d;

   logic              grant;
   logic              done;
   logic              addr_match;
   logic [N_DATA-1:0] ret_data;

   assign grant      = (state_q == IDLE) && (i_mem_req || i_if_ce);
   assign addr_match = (i_if_addr == bus_addr_q);

`ifdef ARB_TIMEOUT_EN
   logic timeout;
   logic cnt_hit;
   logic bus_err_q, bus_err_d;

   arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (grant),
      .i_en    ((state_q != IDLE) && !i_bus_ack),
      .o_hit   (cnt_hit)
   );

   // A real ack in the timeout cycle takes precedence over the timeout
   assign timeout  = (state_q != IDLE) && !i_bus_ack && cnt_hit;
   assign done     = i_bus_ack || timeout;
   assign ret_data = i_bus_ack ? i_bus_rdata : '0;
   assign o_bus_err = bus_err_q;
`else
   logic unused_max_wait;
   assign unused_max_wait = (MAX_WAIT != 0);
   assign done     = i_bus_ack;
   assign ret_data = i_bus_rdata;
`endif

   // Next-state logic: grant from IDLE, complete on ack (or timeout), never grant in the ack cycle
   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_sel_d   = bus_sel_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_vld_d    = 1'b0;
      mem_vld_d   = 1'b0;
      fair_d      = fair_q;
`ifdef ARB_TIMEOUT_EN
      bus_err_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (i_mem_req && !(i_if_ce && fair_q)) begin
               state_d     = MEM_BUSY;
               bus_req_d   = 1'b1;
               bus_we_d    = i_mem_we;
               bus_sel_d   = i_mem_sel;
               bus_addr_d  = i_mem_addr;
               bus_wdata_d = i_mem_wdata;
            end else if (i_if_ce) begin
               state_d     = IF_BUSY;
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_sel_d   = SEL_WORD;
               bus_addr_d  = i_if_addr;
               bus_wdata_d = '0;
               fair_d      = 1'b0;
            end
         end
         IF_BUSY: begin
            if (done) begin
               state_d   = IDLE;
               bus_req_d = 1'b0;
               // Redirected or disabled fetch: data is dropped, the new PC is fetched later
               if (i_if_ce && addr_match) begin
                  if_rdata_d = ret_data;
                  if_vld_d   = 1'b1;
               end
`ifdef ARB_TIMEOUT_EN
               bus_err_d = timeout;
`endif
            end
         end
         MEM_BUSY: begin
            if (done) begin
               state_d     = IDLE;
               bus_req_d   = 1'b0;
               mem_rdata_d = ret_data;
               mem_vld_d   = 1'b1;
               // Fetch was starved by this access: let it win the next tie
               if (i_if_ce) begin
                  fair_d = 1'b1;
               end
`ifdef ARB_TIMEOUT_EN
               bus_err_d = timeout;
`endif
            end
         end
         default: begin
            state_d   = IDLE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transaction in flight
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_sel_q   <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_vld_q    <= 1'b0;
         mem_vld_q   <= 1'b0;
         fair_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         bus_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_sel_q   <= bus_sel_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_vld_q    <= if_vld_d;
         mem_vld_q   <= mem_vld_d;
         fair_q      <= fair_d;
`ifdef ARB_TIMEOUT_EN
         bus_err_q   <= bus_err_d;
`endif
      end
   end

   assign o_bus_req   = bus_req_q;
   assign o_bus_we    = bus_we_q;
   assign o_bus_sel   = bus_sel_q;
   assign o_bus_addr  = bus_addr_q;
   assign o_bus_wdata = bus_wdata_q;
   assign o_if_rdata  = if_rdata_q;
   assign o_if_vld    = if_vld_q;
   assign o_mem_rdata = mem_rdata_q;
   assign o_mem_vld   = mem_vld_q;

   // Stall until the cycle the requester's own access is acknowledged
   assign o_stallreq_mem = i_mem_req && !((state_q == MEM_BUSY) && i_bus_ack);
   assign o_stallreq_if  = i_if_ce && !((state_q == IF_BUSY) && i_bus_ack && addr_match);

endmodule

// File: tb/tb_ibus_dbus_arb.sv
// tb/tb_ibus_dbus_arb.sv - self-checking bench for ibus_dbus_arb
module tb_ibus_dbus_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_if_ce = 1'b0;
   logic [31:0] i_if_addr = '0;
   logic [31:0] o_if_rdata;
   logic        o_if_vld;
   logic        i_mem_req = 1'b0;
   logic        i_mem_we = 1'b0;
   logic [3:0]  i_mem_sel = '0;
   logic [31:0] i_mem_addr = '0;
   logic [31:0] i_mem_wdata = '0;
   logic [31:0] o_mem_rdata;
   logic        o_mem_vld;
   logic        o_bus_req;
   logic        o_bus_we;
   logic [3:0]  o_bus_sel;
   logic [31:0] o_bus_addr;
   logic [31:0] o_bus_wdata;
   logic        i_bus_ack = 1'b0;
   logic [31:0] i_bus_rdata = '0;
   logic        o_stallreq_if;
   logic        o_stallreq_mem;
`ifdef ARB_TIMEOUT_EN
   logic        o_bus_err;
`endif

   int errors = 0;
   int checks = 0;
   int if_vld_cnt = 0;
   int mem_vld_cnt = 0;
   logic [31:0] if_q[$];
   logic [31:0] mem_q[$];

   always #5 clk = ~clk;

   ibus_dbus_arb dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_if_ce        (i_if_ce),
      .i_if_addr      (i_if_addr),
      .o_if_rdata     (o_if_rdata),
      .o_if_vld       (o_if_vld),
      .i_mem_req      (i_mem_req),
      .i_mem_we       (i_mem_we),
      .i_mem_sel      (i_mem_sel),
      .i_mem_addr     (i_mem_addr),
      .i_mem_wdata    (i_mem_wdata),
      .o_mem_rdata    (o_mem_rdata),
      .o_mem_vld      (o_mem_vld),
      .o_bus_req      (o_bus_req),
      .o_bus_we       (o_bus_we),
      .o_bus_sel      (o_bus_sel),
      .o_bus_addr     (o_bus_addr),
      .o_bus_wdata    (o_bus_wdata),
      .i_bus_ack      (i_bus_ack),
      .i_bus_rdata    (i_bus_rdata),
`ifdef ARB_TIMEOUT_EN
      .o_bus_err      (o_bus_err),
`endif
      .o_stallreq_if  (o_stallreq_if),
      .o_stallreq_mem (o_stallreq_mem)
   );

   // Scoreboard: every vld pulse must match the oldest expected response
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_if_vld) begin
            if_vld_cnt++;
            checks++;
            if (if_q.size() == 0) begin
               errors++;
               $display("FAIL if_vld_unexpected: got rdata %h, required no pulse", o_if_rdata);
            end else begin
               logic [31:0] exp_if;
               exp_if = if_q.pop_front();
               if (o_if_rdata !== exp_if) begin
                  errors++;
                  $display("FAIL if_rdata: got %h, required %h", o_if_rdata, exp_if);
               end
            end
         end
         if (o_mem_vld) begin
            mem_vld_cnt++;
            checks++;
            if (mem_q.size() == 0) begin
               errors++;
               $display("FAIL mem_vld_unexpected: got rdata %h, required no pulse", o_mem_rdata);
            end else begin
               logic [31:0] exp_mem;
               exp_mem = mem_q.pop_front();
               if (o_mem_rdata !== exp_mem) begin
                  errors++;
                  $display("FAIL mem_rdata: got %h, required %h", o_mem_rdata, exp_mem);
               end
            end
         end
      end
   end

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (o_bus_req) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({o_bus_req, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_bus: got req=%b we=%b sel=%h addr=%h wdata=%h, required all 0",
                  o_bus_req, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata);
      end
      checks++;
      if ({o_if_vld, o_if_rdata, o_mem_vld, o_mem_rdata, o_stallreq_if, o_stallreq_mem} !== '0) begin
         errors++;
         $display("FAIL reset_resp: got if_vld=%b if_rdata=%h mem_vld=%b mem_rdata=%h, required all 0",
                  o_if_vld, o_if_rdata, o_mem_vld, o_mem_rdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (o_bus_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_req: got %b, required 0", o_bus_req);
      end
   endtask

   task automatic test_fetch_only();
      bit ok;
      int base;
      base = if_vld_cnt;
      i_if_ce = 1'b1;
      i_if_addr = 32'h0;
      wait_req(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL fetch_grant_timeout: got no request, required request");
      end
      checks++;
      if ({o_bus_addr, o_bus_sel, o_bus_we} !== {32'h0, 4'hF, 1'b0}) begin
         errors++;
         $display("FAIL fetch_bus: got addr=%h sel=%h we=%b, required addr=0 sel=f we=0",
                  o_bus_addr, o_bus_sel, o_bus_we);
      end
      @(negedge clk);
      checks++;
      if ({o_bus_req, o_bus_addr, o_stallreq_if} !== {1'b1, 32'h0, 1'b1}) begin
         errors++;
         $display("FAIL fetch_hold: got req=%b addr=%h stall=%b, required 1 0 1",
                  o_bus_req, o_bus_addr, o_stallreq_if);
      end
      @(negedge clk);
      i_bus_ack = 1'b1;
      i_bus_rdata = 32'h3C010101;
      if_q.push_back(32'h3C010101);
      #1;
      checks++;
      if ({o_bus_req, o_stallreq_if} !== 2'b10) begin
         errors++;
         $display("FAIL fetch_ack_cycle: got req=%b stall_if=%b, required req=1 stall_if=0",
                  o_bus_req, o_stallreq_if);
      end
      @(negedge clk);
      i_bus_ack = 1'b0;
      i_if_ce = 1'b0;
      checks++;
      if (o_bus_req !== 1'b0) begin
         errors++;
         $display("FAIL fetch_req_drop: got %b, required 0", o_bus_req);
      end
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (if_vld_cnt != base + 1) begin
         errors++;
         $display("FAIL fetch_vld_count: got %0d, required %0d", if_vld_cnt - base, 1);
      end
   endtask

   task automatic test_fairness();
      bit ok;
      i_if_ce = 1'b1;
      i_if_addr = 32'h8;
      i_mem_req = 1'b1;
      i_mem_we = 1'b1;
      i_mem_sel = 4'h3;
      i_mem_addr = 32'h100;
      i_mem_wdata = 32'hDEADBEEF;
      wait_req(ok);
      checks++;
      if ({ok, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata} !== {1'b1, 1'b1, 4'h3, 32'h100, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL fair_store_first: got ok=%b we=%b sel=%h addr=%h wdata=%h, required 1 1 3 100 deadbeef",
                  ok, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata);
      end
      i_bus_ack = 1'b1;
      i_bus_rdata = 32'h00005A5A;
      mem_q.push_back(32'h00005A5A);
      #1;
      checks++;
      if ({o_stallreq_if, o_stallreq_mem} !== 2'b10) begin
         errors++;
         $display("FAIL fair_store_ack_stall: got if=%b mem=%b, required if=1 mem=0",
                  o_stallreq_if, o_stallreq_mem);
      end
      @(negedge clk);
      i_bus_ack = 1'b0;
      i_mem_we = 1'b0;
      i_mem_sel = 4'hF;
      i_mem_addr = 32'h104;
      i_mem_wdata = 32'h0;
      checks++;
      if (o_stallreq_if !== 1'b1) begin
         errors++;
         $display("FAIL fair_stall_if_gap: got %b, required 1", o_stallreq_if);
      end
      wait_req(ok);
      checks++;
      if ({ok, o_bus_we, o_bus_sel, o_bus_addr, o_stallreq_if} !== {1'b1, 1'b0, 4'hF, 32'h8, 1'b1}) begin
         errors++;
         $display("FAIL fair_fetch_second: got ok=%b we=%b sel=%h addr=%h stall_if=%b, required 1 0 f 8 1",
                  ok, o_bus_we, o_bus_sel, o_bus_addr, o_stallreq_if);
      end
      i_bus_ack = 1'b1;
      i_bus_rdata = 32'h12345678;
      if_q.push_back(32'h12345678);
      @(negedge clk);
      i_bus_ack = 1'b0;
      i_if_ce = 1'b0;
      wait_req(ok);
      checks++;
      if ({ok, o_bus_we, o_bus_addr} !== {1'b1, 1'b0, 32'h104}) begin
         errors++;
         $display("FAIL fair_load_third: got ok=%b we=%b addr=%h, required 1 0 104", ok, o_bus_we, o_bus_addr);
      end
      i_bus_ack = 1'b1;
      i_bus_rdata = 32'hCAFEF00D;
      mem_q.push_back(32'hCAFEF00D);
      @(negedge clk);
      i_bus_ack = 1'b0;
      i_mem_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_redirect();
      bit ok;
      i_if_ce = 1'b1;
      i_if_addr = 32'h10;
      wait_req(ok);
      checks++;
      if ({ok, o_bus_addr} !== {1'b1, 32'h10}) begin
         errors++;
         $display("FAIL redir_first_grant: got ok=%b addr=%h, required 1 10", ok, o_bus_addr);
      end
      @(negedge clk);
      i_if_addr = 32'h40;
      @(negedge clk);
      i_bus_ack = 1'b1;
      i_bus_rdata = 32'hBAD0BAD0;
      #1;
      checks++;
      if (o_stallreq_if !== 1'b1) begin
         errors++;
         $display("FAIL redir_stall_kept: got %b, required 1", o_stallreq_if);
      end
      @(negedge clk);
      i_bus_ack = 1'b0;
      checks++;
      if (o_if_vld !== 1'b0) begin
         errors++;
         $display("FAIL redir_no_vld: got %b, required 0", o_if_vld);
      end
      wait_req(ok);
      checks++;
      if ({ok, o_bus_addr} !== {1'b1, 32'h40}) begin
         errors++;
         $display("FAIL redir_new_grant: got ok=%b addr=%h, required 1 40", ok, o_bus_addr);
      end
      i_bus_ack = 1'b1;
      i_bus_rdata = 32'h600D0040;
      if_q.push_back(32'h600D0040);
      @(negedge clk);
      i_bus_ack = 1'b0;
      i_if_ce = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit ok;
      int base;
      i_mem_req = 1'b1;
      i_mem_we = 1'b0;
      i_mem_sel = 4'hF;
      i_mem_addr = 32'h300;
      wait_req(ok);
      checks++;
      if ({ok, o_bus_addr} !== {1'b1, 32'h300}) begin
         errors++;
         $display("FAIL rstmid_grant: got ok=%b addr=%h, required 1 300", ok, o_bus_addr);
      end
      #2;
      rst_n = 1'b0;
      i_mem_req = 1'b0;
      #1;
      checks++;
      if ({o_bus_req, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata, o_mem_vld, o_mem_rdata, o_if_vld, o_if_rdata} !== '0) begin
         errors++;
         $display("FAIL rstmid_outputs: got req=%b addr=%h mem_rdata=%h if_rdata=%h, required all 0",
                  o_bus_req, o_bus_addr, o_mem_rdata, o_if_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      base = mem_vld_cnt + if_vld_cnt;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({o_bus_req, 32'(mem_vld_cnt + if_vld_cnt - base)} !== {1'b0, 32'd0}) begin
         errors++;
         $display("FAIL rstmid_after: got req=%b stray_vld=%0d, required 0 0",
                  o_bus_req, mem_vld_cnt + if_vld_cnt - base);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      i_mem_req = 1'b1;
      i_mem_we = 1'b0;
      i_mem_sel = 4'hF;
      i_mem_addr = 32'h200;
      wait_req(ok);
      checks++;
      if ({ok, o_bus_addr} !== {1'b1, 32'h200}) begin
         errors++;
         $display("FAIL b2b_first_grant: got ok=%b addr=%h, required 1 200", ok, o_bus_addr);
      end
      i_bus_ack = 1'b1;
      i_bus_rdata = 32'hA0000200;
      mem_q.push_back(32'hA0000200);
      @(negedge clk);
      i_bus_ack = 1'b0;
      i_mem_addr = 32'h204;
      checks++;
      if ({o_bus_req, o_mem_vld} !== 2'b01) begin
         errors++;
         $display("FAIL b2b_idle_gap: got req=%b mem_vld=%b, required req=0 vld=1", o_bus_req, o_mem_vld);
      end
      @(negedge clk);
      checks++;
      if ({o_bus_req, o_bus_addr, o_mem_rdata} !== {1'b1, 32'h204, 32'hA0000200}) begin
         errors++;
         $display("FAIL b2b_second_grant: got req=%b addr=%h held_rdata=%h, required 1 204 a0000200",
                  o_bus_req, o_bus_addr, o_mem_rdata);
      end
      i_bus_ack = 1'b1;
      i_bus_rdata = 32'hA0000204;
      mem_q.push_back(32'hA0000204);
      @(negedge clk);
      i_bus_ack = 1'b0;
      i_mem_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      int held;
      i_mem_req = 1'b1;
      i_mem_we = 1'b0;
      i_mem_addr = 32'h400;
      wait_req(ok);
      held = 0;
      mem_q.push_back(32'h0);
      for (int i = 0; i < 40; i++) begin
         if (!o_bus_req) break;
         held++;
         @(negedge clk);
      end
      i_mem_req = 1'b0;
      checks++;
      if ({ok, 32'(held)} !== {1'b1, 32'd15}) begin
         errors++;
         $display("FAIL timeout_hold: got ok=%b held=%0d, required 1 15", ok, held);
      end
      checks++;
      if ({o_bus_err, o_mem_vld} !== 2'b11) begin
         errors++;
         $display("FAIL timeout_err: got err=%b vld=%b, required 1 1", o_bus_err, o_mem_vld);
      end
      repeat (2) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_fetch_only();
      test_fairness();
      test_redirect();
      test_reset_mid();
      test_back_to_back();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      repeat (2) @(negedge clk);
      checks++;
      if ((if_q.size() + mem_q.size()) != 0) begin
         errors++;
         $display("FAIL missing_vld: got %0d responses outstanding, required 0", if_q.size() + mem_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
